// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter
//   Shares the single L2 request port between the icache and dcache L1
//   controllers. In IDLE it picks one pending requester, latches its request
//   into the L2 output registers and holds that grant until L2 pulses
//   l2_req_fulfilled. The fetched word and the fulfilled pulse are routed
//   combinationally to the granted cache only. Every grant is followed by at
//   least one IDLE bubble cycle.
//
//   Optional feature macro: L2_ARB_ROUND_ROBIN_EN
//     defined   : a tie goes to the requester that did not win the last grant.
//     undefined : a tie always goes to the dcache (fixed priority).
//
//   Ports
//     clk, reset                     clock, asynchronous active-low reset
//     ic_req_address/type/valid      icache request
//     ic_fetched_word/req_fulfilled  icache response
//     dc_req_address/type/store_word/valid  dcache request
//     dc_fetched_word/req_fulfilled  dcache response
//     l2_req_address/type/store_word/valid  registered request to L2
//     l2_fetched_word/req_fulfilled  L2 response

package l2_request_arbiter_pkg;
    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } memory_operation_e;
endpackage

module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [XLEN-1:0]   ic_req_address,
    input  memory_operation_e ic_req_type,
    input  logic              ic_req_valid,
    output logic [XLEN-1:0]   ic_fetched_word,
    output logic              ic_req_fulfilled,

    input  logic [XLEN-1:0]   dc_req_address,
    input  memory_operation_e dc_req_type,
    input  logic [XLEN-1:0]   dc_req_store_word,
    input  logic              dc_req_valid,
    output logic [XLEN-1:0]   dc_fetched_word,
    output logic              dc_req_fulfilled,

    output logic [XLEN-1:0]   l2_req_address,
    output memory_operation_e l2_req_type,
    output logic [XLEN-1:0]   l2_req_store_word,
    output logic              l2_req_valid,
    input  logic [XLEN-1:0]   l2_fetched_word,
    input  logic              l2_req_fulfilled
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IC = 2'd1,
        GRANT_DC = 2'd2
    } state_e;

    localparam logic LAST_IC = 1'b0;
    localparam logic LAST_DC = 1'b1;

    state_e            r_state;
    logic              r_last_grant;
    logic              r_spurious_err;
    logic [XLEN-1:0]   r_address;
    memory_operation_e r_type;
    logic [XLEN-1:0]   r_store_word;
    logic              r_valid;

    logic              w_pick_dc;
    logic              w_ic_done;
    logic              w_dc_done;

    // Winner selection, only consulted while IDLE with at least one valid.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_pick_dc = dc_req_valid;
        if (ic_req_valid && dc_req_valid) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
            w_pick_dc = (r_last_grant == LAST_IC);
`else
            w_pick_dc = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_last_grant   <= LAST_DC;
            r_spurious_err <= 1'b0;
            r_address      <= '0;
            r_type         <= MEM_LOAD;
            r_store_word   <= '0;
            r_valid        <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                IDLE: begin
                    // A completion with nothing outstanding is a protocol error; remember it.
                    if (l2_req_fulfilled) begin
                        r_spurious_err <= 1'b1;
                    end
                    if (ic_req_valid || dc_req_valid) begin
                        r_valid      <= 1'b1;
                        r_last_grant <= w_pick_dc ? LAST_DC : LAST_IC;
                        if (w_pick_dc) begin
                            r_state      <= GRANT_DC;
                            r_address    <= dc_req_address;
                            r_type       <= dc_req_type;
                            r_store_word <= dc_req_store_word;
                        end else begin
                            r_state      <= GRANT_IC;
                            r_address    <= ic_req_address;
                            r_type       <= ic_req_type;
                            r_store_word <= '0;
                        end
                    end
                end
                GRANT_IC, GRANT_DC: begin
                    // Request registers hold; only completion releases the grant.
                    if (l2_req_fulfilled) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Completion is steered to the owner in the same cycle; everyone else sees zeros.
    assign w_ic_done = (r_state == GRANT_IC) && l2_req_fulfilled;
    assign w_dc_done = (r_state == GRANT_DC) && l2_req_fulfilled;

    assign ic_req_fulfilled  = w_ic_done;
    assign dc_req_fulfilled  = w_dc_done;
    assign ic_fetched_word   = w_ic_done ? l2_fetched_word : '0;
    assign dc_fetched_word   = w_dc_done ? l2_fetched_word : '0;

    assign l2_req_address    = r_address;
    assign l2_req_type       = r_type;
    assign l2_req_store_word = r_store_word;
    assign l2_req_valid      = r_valid;

    // Simulation-only visibility of the sticky error flag and of tie history.
    cover property (@(posedge clk) disable iff (!reset) r_spurious_err);
    cover property (@(posedge clk) disable iff (!reset)
        (r_state == IDLE) && ic_req_valid && dc_req_valid && (r_last_grant == LAST_IC));

endmodule

// File: doc/l2_request_arbiter.md
# l2_request_arbiter

Shares the single L2 request port between the icache and dcache L1 controllers. Each cycle it picks one requester, latches that request into registers, drives it to L2, and holds the grant until L2 signals fulfilment. It then routes the fetched word and the fulfilled pulse back to the granted cache only. It sits between the two L1 caches and the L2 cache in the memory subsystem.

## Interface
- XLEN, 32, address/data width in bits
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- ic_req_address  input  XLEN  icache miss address
- ic_req_type  input  memory_operation_e  icache operation
- ic_req_valid  input  1  icache request pending
- ic_fetched_word  output  XLEN  returned word to icache
- ic_req_fulfilled  output  1  icache request complete
- dc_req_address  input  XLEN  dcache request address
- dc_req_type  input  memory_operation_e  dcache operation
- dc_req_store_word  input  XLEN  dcache write data
- dc_req_valid  input  1  dcache request pending
- dc_fetched_word  output  XLEN  returned word to dcache
- dc_req_fulfilled  output  1  dcache request complete
- l2_req_address  output  XLEN  registered request address
- l2_req_type  output  memory_operation_e  registered request type
- l2_req_store_word  output  XLEN  registered write data; 0 for icache grants
- l2_req_valid  output  1  request outstanding to L2
- l2_fetched_word  input  XLEN  L2 returned word
- l2_req_fulfilled  input  1  L2 completion pulse

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT_IC: icache owns the L2 port.
  - GRANT_DC: dcache owns the L2 port.
- IDLE, one or both valids high: arbitrate, latch the winner's address, type and store word into output registers, and move to the matching GRANT state at the next edge.
- IDLE, no valid: remain in IDLE.
- GRANT_x: l2_req_valid is 1. Output registers hold their value regardless of input changes.
- GRANT_x with l2_req_fulfilled=1, same cycle:
  - x_req_fulfilled=1 combinationally.
  - x_fetched_word=l2_fetched_word.
  - Next state is IDLE.
- Non-granted requester: fulfilled=0 and fetched_word=0 at all times.
- l2_fetched_word is forwarded only while in GRANT_x with fulfilled high. Otherwise both fetched_word outputs are 0.
- Requester contract: valid, address, type and store word stay stable until fulfilled. In the cycle after fulfilled, the requester drops valid or presents a new request.
- Arbitration uses a 1-bit last_grant register, updated on every grant (default policy in Configuration).
- l2_req_fulfilled while in IDLE is ignored. No output responds, and a sticky error flag is set (simulation-only assertion).
- A requester that drops valid mid-grant does not cancel the grant. The L2 transaction completes, and the fulfilled pulse still goes to that requester.

## Timing
- Reset (reset=0, asynchronous), all outputs and registers:
  - state=IDLE.
  - l2_req_valid=0, l2_req_address=0, l2_req_type=the enum's first value, l2_req_store_word=0.
  - last_grant=DC, so the icache wins the first tie.
  - Both fulfilled outputs 0 and both fetched_word outputs 0.
- Reset asserted mid-grant: the transaction is abandoned and l2_req_valid falls immediately. L2 is reset in the same domain.
- Latency: requester valid at edge N causes l2_req_valid=1 from edge N+1.
- Fulfilled pass-through is combinational, 0 cycles.
- Back-to-back: fulfilled at cycle M, IDLE at M+1. A pending request is then latched at edge M+1 and l2_req_valid is high again from M+2. This is one bubble cycle minimum between transactions.
- Simultaneous valids in IDLE resolve in one cycle. The loser waits at least one full transaction plus a bubble.

## Configuration
- L2_ARB_ROUND_ROBIN_EN defined: on a tie, the requester not equal to last_grant wins, so alternating ties give IC, DC, IC, DC.
- L2_ARB_ROUND_ROBIN_EN undefined: fixed priority, dcache always wins ties. last_grant is still maintained but not used.
- Non-tie behaviour is identical in both builds.

## Test plan
- Reset mid-grant: assert reset while in GRANT_DC. Required: l2_req_valid=0 with no clock edge. After release, an ic request at 0x40 is granted normally.
- Single icache miss: ic_req_valid=1, address 0x0000_1000, type LOAD, L2 fulfils 3 cycles later with 0xDEAD_BEEF. Required:
  - l2_req_address=0x1000 from the next edge.
  - ic_fetched_word=0xDEAD_BEEF on the fulfilled cycle.
  - ic_req_fulfilled pulses exactly once.
  - dc outputs stay 0 throughout.
- Simultaneous requests, ic 0x100 and dc 0x200 both valid from reset. Required:
  - Round-robin build: IC granted first, then DC after one bubble.
  - Fixed-priority build: DC first.
- Repeated ties across 4 transactions (round-robin build). Required: grant order IC, DC, IC, DC, with l2_req_valid low for exactly 1 cycle between transactions.
- Input change during grant: dcache store to 0x300 with data 0x1234_5678 granted; ic_req_address toggles every cycle during the grant. Required: l2_req_address stays 0x300 and l2_req_store_word stays 0x1234_5678 until fulfilled.
- Spurious fulfilled: l2_req_fulfilled=1 in IDLE. Required: both fulfilled outputs stay 0, the state is unchanged, and the assertion flag is set.
